// File: rtl/pe_feed_pkg.sv
// pe_feed_pkg: shared state encoding and size helpers for the PE vector feeder.
package pe_feed_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    function automatic int depth_of(input int l_ram_size);
        return 1 << (l_ram_size + 1);
    endfunction

    function automatic int addr_w_of(input int l_ram_size);
        return l_ram_size + 1;
    endfunction

    localparam int L_RAM_SIZE_DEF = 3;
    localparam int DEPTH_DEF      = depth_of(L_RAM_SIZE_DEF);
    localparam int ADDR_W_DEF     = addr_w_of(L_RAM_SIZE_DEF);

endpackage

// File: rtl/pe_feed_ram.sv
// pe_feed_ram: simple dual-port RAM, one write and one registered read port.
// The array is never reset; only the read register clears on aresetn.
module pe_feed_ram #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SIZE-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SIZE-1:0]   rdata
);

    logic [SIZE-1:0] mem [2**ADDR_W];

    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Separate register keeps read-during-write returning the old word.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rdata <= '0;
        else          rdata <= mem[raddr];
    end

endmodule

// File: rtl/pe_vec_feeder.sv
// pe_vec_feeder: buffers one operand set from a valid/ready stream, pulses start,
// then serves the PE controller read port until done. Option: PE_FEED_OVF_EN adds ovf.
module pe_vec_feeder
    import pe_feed_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int L_RAM_SIZE = 3
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SIZE-1:0]     s_data,
    output logic                start,
    input  logic                done,
    input  logic [L_RAM_SIZE:0] rdaddr,
    output logic [SIZE-1:0]     rddata,
    output logic                busy
`ifdef PE_FEED_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int DEPTH  = depth_of(L_RAM_SIZE);
    localparam int ADDR_W = addr_w_of(L_RAM_SIZE);

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic              we, last;

    assign s_ready = state == S_LOAD;
    assign start   = state == S_ARM;
    assign busy    = state == S_ARM || state == S_RUN;
    assign we      = s_valid && s_ready;
    assign last    = wr_ptr == ADDR_W'(DEPTH - 1);

    always_comb begin
        state_n = state;
        case (state)
            S_LOAD:  state_n = (we && last) ? S_ARM : S_LOAD;
            S_ARM:   state_n = S_RUN;
            S_RUN:   state_n = done ? S_LOAD : S_RUN;
            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_LOAD;
        else          state <= state_n;
    end

    // The final write leaves LOAD, so the pointer is re-zeroed on exit from RUN.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                     wr_ptr <= '0;
        else if (state == S_RUN && done)  wr_ptr <= '0;
        else if (we)                      wr_ptr <= wr_ptr + 1'b1;
    end

`ifdef PE_FEED_OVF_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                ovf <= 1'b0;
        else if (s_valid && !s_ready) ovf <= 1'b1;
    end
`endif

    pe_feed_ram #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (we),
        .waddr   (wr_ptr),
        .wdata   (s_data),
        .raddr   (rdaddr),
        .rdata   (rddata)
    );

endmodule

// File: tb/tb_pe_vec_feeder.sv
// tb_pe_vec_feeder: directed stimulus with a read-data scoreboard and status checks.
module tb_pe_vec_feeder;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       start;
    logic       done = 1'b0;
    logic [3:0] rdaddr = '0;
    logic [7:0] rddata;
    logic       busy;
`ifdef PE_FEED_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int acc   = 0;
    logic rd_vld = 1'b0;
    logic rd_vld_d = 1'b0;
    logic [7:0] exp_q [$];

    pe_vec_feeder #(.SIZE(8), .L_RAM_SIZE(3)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .start   (start),
        .done    (done),
        .rdaddr  (rdaddr),
        .rddata  (rddata),
        .busy    (busy)
`ifdef PE_FEED_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (s_valid && s_ready) acc <= acc + 1;
        rd_vld_d <= rd_vld;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each read issued one cycle earlier must present its word now.
    always @(negedge aclk) begin
        if (rd_vld_d) begin
            if (exp_q.size() == 0) chk("rd_underflow", 1, 0);
            else chk("rddata", {24'd0, rddata}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic load_b2b(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 8'(i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e);
        rdaddr = a;
        rd_vld = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_vld = 1'b0;
    endtask

    task automatic finish_run;
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge aclk);
        chk("ready_after_done", {31'd0, s_ready}, 1);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        repeat (3) tick();
        @(negedge aclk);
        chk("rst_start", {31'd0, start}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rddata", {24'd0, rddata}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_ready", {31'd0, s_ready}, 1);
        tick();

        // Back-to-back load 0x00..0x0F
        a0 = acc;
        load_b2b(8'h00, 15);
        chk("start_early", {31'd0, start}, 0);
        load_b2b(8'h0F, 1);
        @(negedge aclk);
        chk("b2b_accepts", acc - a0, 16);
        chk("arm_start", {31'd0, start}, 1);
        chk("arm_ready", {31'd0, s_ready}, 0);
        chk("arm_busy", {31'd0, busy}, 1);
        tick();
        @(negedge aclk);
        chk("run_start", {31'd0, start}, 0);
        chk("run_busy", {31'd0, busy}, 1);
        chk("run_ready", {31'd0, s_ready}, 0);
        tick();
        for (int i = 0; i < 16; i++) rd(4'(i), 8'(i));
        finish_run();
        tick();

        // Gapped load 0xA0..0xAF
        a0 = acc;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'hA0 + 8'(i);
            tick();
            s_valid = 1'b0;
            tick();
        end
        chk("gap_accepts", acc - a0, 16);
        chk("gap_busy", {31'd0, busy}, 1);
        rd(4'd15, 8'hAF);
        rd(4'd0, 8'hA0);
        finish_run();
        tick();

        // done during LOAD must be ignored
        load_b2b(8'hB0, 5);
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge aclk);
        chk("load_done_ready", {31'd0, s_ready}, 1);
        chk("load_done_busy", {31'd0, busy}, 0);
        tick();
        load_b2b(8'hB5, 10);
        chk("load_done_early", {31'd0, start}, 0);
        load_b2b(8'hBF, 1);
        @(negedge aclk);
        chk("load_done_start", {31'd0, start}, 1);
        tick();
        rd(4'd4, 8'hB4);
        rd(4'd5, 8'hB5);
        rd(4'd15, 8'hBF);
        finish_run();
        tick();

        // Reset mid-load clears the write pointer
        load_b2b(8'h50, 3);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("mrst_start", {31'd0, start}, 0);
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_rddata", {24'd0, rddata}, 0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mrst_ready", {31'd0, s_ready}, 1);
        tick();
        load_b2b(8'hC0, 15);
        chk("mrst_early", {31'd0, start}, 0);
        load_b2b(8'hCF, 1);
        @(negedge aclk);
        chk("mrst_start2", {31'd0, start}, 1);
        tick();
        rd(4'd0, 8'hC0);
        rd(4'd15, 8'hCF);
`ifdef PE_FEED_OVF_EN
        chk("ovf_clear", {31'd0, ovf}, 0);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("ovf_set", {31'd0, ovf}, 1);
`endif
        finish_run();
        tick();
`ifdef PE_FEED_OVF_EN
        load_b2b(8'hD0, 2);
        chk("ovf_sticky", {31'd0, ovf}, 1);
        aresetn = 1'b0;
        #1;
        chk("ovf_rst", {31'd0, ovf}, 0);
        tick();
        aresetn = 1'b1;
`endif
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
